// File: rtl/piso_frame_tx_if.sv
// Handshake and serial-line bundle for piso_frame_tx.
// The DUT attaches to "slave"; the upstream word source and line observer attach to "master".
interface piso_frame_tx_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_out;
    logic              busy;
    logic              done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx_out,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx_out,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, LSB-first payload, optional even parity, stop bits.
// Defining TX_PARITY_EN inserts an even-parity bit between the payload and the stop bits.
module piso_frame_tx #(
    parameter int DATA_W    = 4,
    parameter int DIV       = 4,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst_n,
    piso_frame_tx_if.slave bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic              tx_reg;
    logic              done_reg;
`ifdef TX_PARITY_EN
    logic              parity_reg;
`endif

    logic              div_last;
    logic [DATA_W-1:0] shreg_next;

    always_comb begin
        div_last   = (div_cnt_reg == DIV_LAST);
        shreg_next = shreg_reg >> 1;
    end

    // bit_cnt doubles as the stop-bit index once the payload is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
`ifdef TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg   <= START;
                        shreg_reg   <= bus.in_data;
                        tx_reg      <= 1'b0;
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
`ifdef TX_PARITY_EN
                        parity_reg  <= ^bus.in_data;
`endif
                    end
                end
                START: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        state_reg   <= DATA;
                        tx_reg      <= shreg_reg[0];
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        shreg_reg   <= shreg_next;
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
`ifdef TX_PARITY_EN
                            state_reg   <= PARITY;
                            tx_reg      <= parity_reg;
`else
                            state_reg   <= STOP;
                            tx_reg      <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            tx_reg      <= shreg_next[0];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        state_reg   <= STOP;
                        tx_reg      <= 1'b1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= IDLE;
                            done_reg    <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = (state_reg == IDLE);
    assign bus.busy     = (state_reg != IDLE);
    assign bus.tx_out   = tx_reg;
    assign bus.done     = done_reg;
endmodule
